// File: rtl/even_odd_sched_if.sv
// Request/counter bundle for even_odd_sched: requester inputs, shared-counter link and run status.
interface even_odd_sched_if #(
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [1:0]       req_up;
    logic [LEN_W-1:0] req_len0;
    logic [LEN_W-1:0] req_len1;
    logic             abort;
    logic [2:0]       q_in;
    logic             ctr_rst;
    logic             ctr_up;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [2:0]       res_q;

    modport master (
        output req, req_up, req_len0, req_len1, abort, q_in,
        input  ctr_rst, ctr_up, gnt, busy, done, aborted, res_q
    );

    modport slave (
        input  req, req_up, req_len0, req_len1, abort, q_in,
        output ctr_rst, ctr_up, gnt, busy, done, aborted, res_q
    );
endinterface

// File: rtl/even_odd_sched.sv
// Round-robin scheduler granting one of two requesters a timed run of the shared even/odd counter.
module even_odd_sched #(
    parameter int LEN_W = 4
) (
    input logic             clk,
    input logic             rst,
    even_odd_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             up_q, up_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             aborted_q, aborted_d;
    logic [2:0]       res_q_q, res_q_d;
    logic             win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            up_q      <= 1'b0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            res_q_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            up_q      <= up_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
            res_q_q   <= res_q_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        up_d      = up_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        res_q_d   = res_q_q;
        win       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // last_q doubles as the round-robin pointer and the granted index of the current run
                if (|bus.req) begin
                    win     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    last_d  = win;
                    up_d    = bus.req_up[win];
                    cnt_d   = win ? bus.req_len1 : bus.req_len0;
                    state_d = CLR;
                end
            end
            CLR: begin
                if (cnt_q != '0) begin
                    state_d = RUN;
                end else begin
                    aborted_d = 1'b0;
                    state_d   = FIN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else if (cnt_q == LEN_W'(1)) begin
                    aborted_d = 1'b0;
                    state_d   = FIN;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            FIN: begin
                res_q_d = bus.q_in;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == FIN);
    assign bus.ctr_rst = (state_q != RUN);
    assign bus.ctr_up  = (state_q != IDLE) ? up_q : 1'b0;
    assign bus.gnt     = (state_q == IDLE) ? 2'b00 : (last_q ? 2'b10 : 2'b01);
    assign bus.aborted = aborted_q;
    assign bus.res_q   = res_q_q;
endmodule

// File: tb/tb_even_odd_sched.sv
// Scoreboard bench for even_odd_sched: driver predicts each run, monitor checks it at the done pulse.
module tb_even_odd_sched;
    localparam int LEN_W = 4;

    typedef struct {
        logic [1:0] gnt;
        int         runs;
        logic       up;
        logic       ab;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   rr_last = 1;
    exp_t exp_q[$];

    even_odd_sched_if #(.LEN_W(LEN_W)) bus ();
    even_odd_sched #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // counter value is free-running noise so a mistimed res_q capture is visible
    always @(posedge clk) begin
        #2;
        bus.q_in = 3'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    bit         active = 0;
    bit         chk_res = 0;
    logic [1:0] first_gnt;
    logic       first_up;
    bit         gnt_ok, up_ok;
    int         low;
    logic [2:0] q_fin;
    logic       ab_fin;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            active  = 0;
            chk_res = 0;
        end else begin
            if (chk_res) begin
                chk("res_q", bus.res_q, q_fin);
                chk("aborted_hold", bus.aborted, ab_fin);
                chk_res = 0;
            end
            if (bus.busy) begin
                if (!active) begin
                    active    = 1;
                    first_gnt = bus.gnt;
                    first_up  = bus.ctr_up;
                    gnt_ok    = 1;
                    up_ok     = 1;
                    low       = 0;
                end
                if (bus.gnt !== first_gnt) gnt_ok = 0;
                if (!bus.done && bus.ctr_up !== first_up) up_ok = 0;
                if (bus.ctr_rst === 1'b0) low++;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("gnt", first_gnt, e.gnt);
                        chk("gnt_stable", gnt_ok, 1);
                        chk("run_cycles", low, e.runs);
                        chk("ctr_up", first_up, e.up);
                        chk("ctr_up_stable", up_ok, 1);
                        chk("aborted", bus.aborted, e.ab);
                        chk("done_cycle", cyc, e.cyc);
                        q_fin   = bus.q_in;
                        ab_fin  = e.ab;
                        chk_res = 1;
                    end
                    active = 0;
                end
            end else begin
                active = 0;
                chk("idle_gnt", bus.gnt, 0);
                chk("idle_ctr_rst", bus.ctr_rst, 1);
                chk("idle_done", bus.done, 0);
            end
        end
    end

    // Driver: called at a negedge with the DUT in IDLE
    task automatic run_txn(input logic [1:0] r, input logic [1:0] up, input logic [3:0] l0,
                           input logic [3:0] l1, input int ak, input bit clr_ab, input bit junk,
                           input int mid_len0);
        int   w, len, runs;
        bit   ab;
        exp_t e;
        w    = (r == 2'b11) ? 1 - rr_last : (r[1] ? 1 : 0);
        len  = (w == 1) ? int'(l1) : int'(l0);
        ab   = (ak >= 1 && ak <= len);
        runs = ab ? ak : len;
        e.gnt  = (w == 1) ? 2'b10 : 2'b01;
        e.runs = runs;
        e.up   = up[w];
        e.ab   = ab;
        e.cyc  = cyc + 2 + runs;
        exp_q.push_back(e);
        rr_last = w;
        bus.req      = r;
        bus.req_up   = up;
        bus.req_len0 = l0;
        bus.req_len1 = l1;
        bus.abort    = 1'b0;
        @(negedge clk);
        bus.req   = 2'b00;
        bus.abort = clr_ab;
        for (int k = 1; k <= runs + 1; k++) begin
            @(negedge clk);
            bus.abort = (k == ak);
            if (k == 1 && mid_len0 >= 0) bus.req_len0 = 4'(mid_len0);
            if (junk && k <= runs) begin
                bus.req      = 2'($urandom);
                bus.req_up   = 2'($urandom);
                bus.req_len0 = 4'($urandom);
                bus.req_len1 = 4'($urandom);
            end
            if (k == runs + 1) bus.req = 2'b00;
        end
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic b2b(input int nruns);
        int   w;
        exp_t e;
        bus.req_len0 = 4'd2;
        bus.req_len1 = 4'd2;
        bus.req_up   = 2'b10;
        bus.abort    = 1'b0;
        for (int n = 0; n < nruns; n++) begin
            w      = 1 - rr_last;
            e.gnt  = (w == 1) ? 2'b10 : 2'b01;
            e.runs = 2;
            e.up   = (w == 1);
            e.ab   = 1'b0;
            e.cyc  = cyc + 5 * n + 4;
            exp_q.push_back(e);
            rr_last = w;
        end
        bus.req = 2'b11;
        repeat (5 * (nruns - 1) + 1) @(negedge clk);
        bus.req = 2'b00;
        repeat (6) @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_aborted"}, bus.aborted, 0);
        chk({tag, "_res_q"}, bus.res_q, 0);
        chk({tag, "_ctr_rst"}, bus.ctr_rst, 1);
        chk({tag, "_ctr_up"}, bus.ctr_up, 0);
    endtask

    task automatic reset_mid();
        bus.req      = 2'b01;
        bus.req_up   = 2'b01;
        bus.req_len0 = 4'd6;
        bus.abort    = 1'b0;
        @(negedge clk);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 reset_checks("midrun_rst");
        rr_last = 1;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int ak;
        logic [3:0] l0, l1;
        bus.req      = 2'b00;
        bus.req_up   = 2'b00;
        bus.req_len0 = '0;
        bus.req_len1 = '0;
        bus.abort    = 1'b0;
        bus.q_in     = 3'd0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        #2 rst = 1'b1;
        @(negedge clk);

        b2b(4);
        run_txn(2'b01, 2'b01, 4'd3, 4'd9, 0, 1'b0, 1'b0, -1);
        run_txn(2'b10, 2'b00, 4'd5, 4'd0, 0, 1'b1, 1'b0, -1);
        run_txn(2'b01, 2'b00, 4'd7, 4'd2, 3, 1'b0, 1'b0, -1);
        run_txn(2'b01, 2'b01, 4'd5, 4'd3, 0, 1'b0, 1'b0, 1);
        run_txn(2'b11, 2'b11, 4'd15, 4'd15, 0, 1'b0, 1'b0, -1);
        run_txn(2'b11, 2'b01, 4'd15, 4'd15, 16, 1'b0, 1'b0, -1);
        reset_mid();
        run_txn(2'b11, 2'b10, 4'd2, 4'd4, 0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 150; i++) begin
            l0 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15) : 4'($urandom);
            l1 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15) : 4'($urandom);
            ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0;
            run_txn(2'($urandom_range(1, 3)), 2'($urandom), l0, l1, ak,
                    1'($urandom), 1'b1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("pending_runs", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, runs pending %0d expected 0", exp_q.size());
        $fatal(1);
    end
endmodule
